// File: rtl/spi_frame_pkg.sv
// Shared frame geometry and FSM state type for the SPI write-frame receiver.
package spi_frame_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

  // The counter stops at one past a full frame, so any long frame stays distinguishable.
  localparam logic [CNT_W-1:0] CNT_FRAME = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT   = 5'd17;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for one asynchronous pin, with a selectable reset level.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {DEPTH{RST_VAL}};
    else        chain_q <= chain_d;
  end

  assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 receiver for 16-bit write frames {rw, addr[6:0], data[7:0]} with
// synchronized pins, one-cycle valid/error pulses and held frame outputs.
module spi_frame_rx
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ncs,
  input  logic              sclk,
  input  logic              copi,
  output logic              frame_valid,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  output logic              busy
);

  logic ncs_s, sclk_s, copi_s;
  logic ncs_dly_q, ncs_dly_d;
  logic sclk_dly_q, sclk_dly_d;
  logic ncs_fall, ncs_rise, sclk_rise;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  // ncs idles high, so its chain resets to 1; a held-low ncs at release reads as a fall.
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs), .q(ncs_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));

  assign ncs_fall  = ~ncs_s & ncs_dly_q;
  assign ncs_rise  = ncs_s & ~ncs_dly_q;
  assign sclk_rise = sclk_s & ~sclk_dly_q;

  always_comb begin
    ncs_dly_d  = ncs_s;
    sclk_dly_d = sclk_s;
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = RECV;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      RECV: begin
        // A chip-select edge wins over a coincident sclk edge, which is dropped.
        if (ncs_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_FRAME) begin
            if (shift_q[FRAME_BITS-1]) begin
              addr_d  = shift_q[FRAME_BITS-2 -: ADDR_W];
              data_d  = shift_q[DATA_W-1:0];
              valid_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_dly_q  <= 1'b1;
      sclk_dly_q <= 1'b0;
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ncs_dly_q  <= ncs_dly_d;
      sclk_dly_q <= sclk_dly_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign frame_addr  = addr_q;
  assign frame_data  = data_q;
  assign busy        = (state_q == RECV);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: frames are driven at the pins, a frame-level
// model predicts each pulse and the held address/data, and a monitor checks every cycle.
module tb_spi_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ncs = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       frame_valid;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  logic idle_chk = 1'b0;

  // Expected pulses in order: {is_err, addr[6:0], data[7:0]}.
  logic [15:0] exp_q[$];
  logic [6:0]  mdl_addr = '0;
  logic [7:0]  mdl_data = '0;

  spi_frame_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
    .frame_valid(frame_valid), .frame_addr(frame_addr), .frame_data(frame_data),
    .frame_err(frame_err), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level prediction: what a frame of nbits bits with this content must produce.
  task automatic predict(input logic [31:0] v, input int nbits);
    if (nbits != 16)   exp_q.push_back(16'h8000);
    else if (v[15])    exp_q.push_back({1'b0, v[14:8], v[7:0]});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Lower ncs and clock out nbits bits MSB-first; ncs is left low.
  task automatic spi_bits(input logic [31:0] v, input int nbits, input int half);
    ncs = 1'b0;
    wait_cyc(half);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = v[i];
      wait_cyc(half);
      sclk = 1'b1;
      wait_cyc(half);
      sclk = 1'b0;
    end
    wait_cyc(half);
  endtask

  task automatic spi_frame(input logic [31:0] v, input int nbits, input int half);
    predict(v, nbits);
    spi_bits(v, nbits, half);
    ncs = 1'b1;
    wait_cyc(12);
  endtask

  // Monitor: every cycle, compare pulses against the expected queue and the held outputs.
  always @(posedge clk) begin
    logic [15:0] e;
    #1;
    if (!rst_n) begin
      mdl_addr = '0;
      mdl_data = '0;
      chk("reset_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
    end else begin
      if (frame_valid && frame_err) chk("valid_err_exclusive", 32'd1, 32'd0);
      if (frame_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("valid_kind", {31'd0, e[15]}, 32'd0);
          mdl_addr = e[14:8];
          mdl_data = e[7:0];
        end
      end
      if (frame_err) begin
        err_cnt++;
        if (exp_q.size() == 0) chk("unexpected_err", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("err_kind", {31'd0, e[15]}, 32'd1);
        end
      end
      if (idle_chk) chk("busy_idle", {31'd0, busy}, 32'd0);
    end
    chk("frame_addr", 32'(frame_addr), 32'(mdl_addr));
    chk("frame_data", 32'(frame_data), 32'(mdl_data));
  end

  initial begin
    int v0, e0;
    wait_cyc(3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", 32'(frame_addr), 32'd0);
    chk("rst_data", 32'(frame_data), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Write frame 0x84,0x80.
    v0 = valid_cnt; e0 = err_cnt;
    spi_frame(32'h8480, 16, 8);
    chk("wr1_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    chk("wr1_err_cnt", 32'(err_cnt - e0), 32'd0);
    chk("wr1_addr", 32'(frame_addr), 32'h04);
    chk("wr1_data", 32'(frame_data), 32'h80);

    // Read frame 0x04,0x55: silent, outputs held.
    v0 = valid_cnt; e0 = err_cnt;
    spi_frame(32'h0455, 16, 8);
    chk("rd_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    chk("rd_err_cnt", 32'(err_cnt - e0), 32'd0);
    chk("rd_addr", 32'(frame_addr), 32'h04);
    chk("rd_data", 32'(frame_data), 32'h80);

    // 12-bit, 17-bit and empty frames: all errors.
    v0 = valid_cnt; e0 = err_cnt;
    spi_frame(32'h0000_0ABC, 12, 4);
    spi_frame(32'h0001_8123, 17, 4);
    spi_frame(32'h0, 0, 4);
    chk("bad_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    chk("bad_err_cnt", 32'(err_cnt - e0), 32'd3);
    chk("bad_addr", 32'(frame_addr), 32'h04);

    // Reset mid-frame, then a full write frame.
    v0 = valid_cnt; e0 = err_cnt;
    spi_bits(32'h0000_0081, 8, 4);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(8);
    chk("postrst_addr", 32'(frame_addr), 32'd0);
    spi_frame(32'h81FF, 16, 4);
    chk("rst_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    chk("rst_err_cnt", 32'(err_cnt - e0), 32'd0);
    chk("rst_wr_addr", 32'(frame_addr), 32'h01);
    chk("rst_wr_data", 32'(frame_data), 32'hFF);

    // sclk toggling with ncs high is ignored.
    v0 = valid_cnt; e0 = err_cnt;
    idle_chk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      copi = 1'($urandom_range(0, 1));
      wait_cyc(4); sclk = 1'b1;
      wait_cyc(4); sclk = 1'b0;
    end
    wait_cyc(8);
    idle_chk = 1'b0;
    chk("idle_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    chk("idle_err_cnt", 32'(err_cnt - e0), 32'd0);

    // ncs held low across reset release starts a frame.
    v0 = valid_cnt;
    ncs = 1'b0;
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    spi_frame(32'h853C, 16, 4);
    chk("lowrel_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    chk("lowrel_addr", 32'(frame_addr), 32'h05);
    chk("lowrel_data", 32'(frame_data), 32'h3C);

    // Pulse latency from the ncs pin rise.
    predict(32'hAA5A, 16);
    spi_bits(32'hAA5A, 16, 4);
    ncs = 1'b1;
    @(posedge clk); #1 chk("lat_edge1", {31'd0, frame_valid}, 32'd0);
    @(posedge clk); #1 chk("lat_edge2", {31'd0, frame_valid}, 32'd0);
    @(posedge clk); #1 chk("lat_edge3", {31'd0, frame_valid}, 32'd1);
    @(posedge clk); #1 chk("lat_edge4", {31'd0, frame_valid}, 32'd0);
    wait_cyc(6);
    chk("lat_addr", 32'(frame_addr), 32'h2A);
    chk("lat_data", 32'(frame_data), 32'h5A);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on each SPI pin input (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: system clock; single clock domain for all state.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ncs, input, 1 bit: SPI chip select, active low, asynchronous to clk.
REQ-005 SHALL have port sclk, input, 1 bit: SPI clock, mode 0, asynchronous to clk.
REQ-006 SHALL have port copi, input, 1 bit: SPI controller-out data, asynchronous to clk.
REQ-007 SHALL have port frame_valid, output, 1 bit: one-cycle pulse marking an accepted write frame.
REQ-008 SHALL have port frame_addr, output, 7 bits: register address of the last accepted frame.
REQ-009 SHALL have port frame_data, output, 8 bits: data byte of the last accepted frame.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse marking a malformed frame.
REQ-011 SHALL have port busy, output, 1 bit: high while the FSM is in RECV.

Function
REQ-012 SHALL pass ncs, sclk and copi each through a SYNC_STAGES-deep flop chain before any use.
REQ-013 SHALL detect edges on synchronized ncs and sclk by comparing against a one-cycle-delayed copy.
REQ-014 SHALL use two states: IDLE, RECV.
REQ-015 SHALL move IDLE->RECV on a synchronized ncs falling edge, clearing the shift register and the 5-bit bit counter.
REQ-016 SHALL, in RECV, on each synchronized sclk rising edge, shift synchronized copi in MSB-first and increment the bit counter, saturating at 17.
REQ-017 SHALL move RECV->IDLE on a synchronized ncs rising edge and evaluate the frame in that same cycle.
REQ-018 SHALL define the frame as 16 bits: bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
REQ-019 SHALL, when count == 16 and R/W == 1, load frame_addr/frame_data and pulse frame_valid for exactly one cycle.
REQ-020 SHALL, when count == 16 and R/W == 0, take no action: no pulse, outputs unchanged.
REQ-021 SHALL, when count != 16 (short frame, including 0, or long frame of 17+ bits), pulse frame_err for one cycle and leave frame_addr/frame_data unchanged.
REQ-022 SHALL register frame_valid and frame_err, asserting them after the (SYNC_STAGES+1)th rising clk edge following the ncs pin rise (3 edges at the default).
REQ-023 SHALL hold frame_addr/frame_data stable between accepted frames.
REQ-024 SHALL ignore sclk edges in IDLE.
REQ-025 SHALL give an ncs edge precedence when it occurs in the same synchronized cycle as an sclk rising edge; that sclk edge is discarded.
REQ-026 SHALL guarantee correct capture only when each sclk high and low phase lasts at least SYNC_STAGES+1 clk periods; faster sclk behaviour is undefined.
REQ-027 SHALL never assert frame_valid and frame_err in the same cycle.

Reset
REQ-028 SHALL, on rst_n low, immediately force: state IDLE, counter 0, shift register 0, frame_addr 0, frame_data 0, frame_valid 0, frame_err 0, busy 0.
REQ-029 SHALL reset ncs synchronizer and delay flops to 1, and sclk/copi flops to 0.
REQ-030 SHALL discard any partial frame when reset is asserted mid-frame, with no pulse on either output.
REQ-031 SHALL treat ncs held low at reset release as a falling edge, starting RECV.

Structure
REQ-032 SHALL take FRAME_BITS=16, ADDR_W=7, DATA_W=8 and the IDLE/RECV state type from a shared package spi_frame_pkg.
REQ-033 SHALL implement the synchronizer as sub-module sync_ff, parameterized by depth and reset value, instantiated three times.

Verification
REQ-034 SHALL cover this scenario: write frame 0x84,0x80 at 8 clk/half-sclk -> single frame_valid, addr 0x04, data 0x80, frame_err stays 0.
REQ-035 SHALL cover this scenario: read frame 0x04,0x55 -> no frame_valid, no frame_err, outputs keep their prior values.
REQ-036 SHALL cover this scenario: 12-bit frame, then 17-bit frame -> two frame_err pulses, outputs unchanged.
REQ-037 SHALL cover this scenario: rst_n pulsed after 8 bits, then full write frame 0x81,0xFF -> only one frame_valid, addr 0x01, data 0xFF.
REQ-038 SHALL cover this scenario: 20 sclk pulses with ncs high -> busy, frame_valid and frame_err all stay 0.
REQ-039 SHALL cover this scenario: ncs rise at the pin -> frame_valid high after exactly the 3rd clk edge, low on the next.
